// File: rtl/lanectrl_pkg.sv
// Shared lane-control definitions: FSM state encoding and default pause timing.
package lanectrl_pkg;

    // Delay-code width, shared with the training sequencer.
    localparam int unsigned CODE_W = 8;

    // Default phase lengths in CLK cycles.
    localparam int unsigned PRE_CYCLES_DEF  = 2;
    localparam int unsigned HOLD_CYCLES_DEF = 4;
    localparam int unsigned GAP_CYCLES_DEF  = 8;
    localparam int unsigned CNT_W_DEF       = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_LOAD = 3'd2,
        ST_HOLD = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

endpackage

// File: rtl/lanectrl_phase_cnt.sv
// Loadable down-counter with a zero flag, reused by every timed pause phase.
module lanectrl_phase_cnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [CNT_W-1:0] count;

    // Load takes priority; decrement is only requested while nonzero, so no wrap.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/lanectrl_pause_gen.sv
// Initiator of HS_IO_CLK_PAUSE windows around delay-code loads for the DDR PHY lanes.
module lanectrl_pause_gen
    import lanectrl_pkg::*;
#(
    parameter int unsigned PRE_CYCLES  = PRE_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int unsigned CODE_W      = lanectrl_pkg::CODE_W,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ_VALID,
    input  logic [CODE_W-1:0] REQ_CODE,
    output logic              REQ_READY,
    output logic              HS_IO_CLK_PAUSE,
    output logic              DELAY_LOAD,
    output logic [CODE_W-1:0] DELAY_CODE,
    output logic              DONE,
    output logic              BUSY
);

    // Reject parameter sets that would break the synchronizer margin or overflow the counter.
    if (PRE_CYCLES < 1 || PRE_CYCLES > 15) begin : g_bad_pre
        $fatal(1, "lanectrl_pause_gen: PRE_CYCLES out of range 1..15");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
        $fatal(1, "lanectrl_pause_gen: HOLD_CYCLES out of range 1..15");
    end
    if (GAP_CYCLES < 2 || GAP_CYCLES > 15) begin : g_bad_gap
        $fatal(1, "lanectrl_pause_gen: GAP_CYCLES out of range 2..15");
    end
    if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cntw
        $fatal(1, "lanectrl_pause_gen: CNT_W out of range 1..16");
    end
    if ((PRE_CYCLES > (2 ** CNT_W)) || (HOLD_CYCLES > (2 ** CNT_W)) ||
        (GAP_CYCLES > (2 ** CNT_W))) begin : g_bad_fit
        $fatal(1, "lanectrl_pause_gen: CNT_W too narrow for phase lengths");
    end

    localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);

    state_t           state;
    logic             cnt_load_c;
    logic [CNT_W-1:0] cnt_val_c;
    logic             cnt_dec_c;
    logic             cnt_zero_c;

    // Counter control: load on phase entry, count down inside a phase.
    always_comb begin
        cnt_load_c = 1'b0;
        cnt_val_c  = '0;
        cnt_dec_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    cnt_load_c = 1'b1;
                    cnt_val_c  = PRE_LD;
                end
            end
            ST_PRE:  cnt_dec_c = !cnt_zero_c;
            ST_LOAD: begin
                cnt_load_c = 1'b1;
                cnt_val_c  = HOLD_LD;
            end
            ST_HOLD: begin
                if (cnt_zero_c) begin
                    cnt_load_c = 1'b1;
                    cnt_val_c  = GAP_LD;
                end else begin
                    cnt_dec_c = 1'b1;
                end
            end
            ST_GAP:  cnt_dec_c = !cnt_zero_c;
            default: begin
                cnt_load_c = 1'b0;
            end
        endcase
    end

    lanectrl_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .load     (cnt_load_c),
        .load_val (cnt_val_c),
        .dec      (cnt_dec_c),
        .zero_c   (cnt_zero_c)
    );

    // Window sequencing; outputs are registered alongside the state they describe.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state           <= ST_IDLE;
            REQ_READY       <= 1'b1;
            HS_IO_CLK_PAUSE <= 1'b0;
            DELAY_LOAD      <= 1'b0;
            DELAY_CODE      <= '0;
            DONE            <= 1'b0;
            BUSY            <= 1'b0;
        end else begin
            DELAY_LOAD <= 1'b0;
            DONE       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        state           <= ST_PRE;
                        DELAY_CODE      <= REQ_CODE;
                        HS_IO_CLK_PAUSE <= 1'b1;
                        BUSY            <= 1'b1;
                        REQ_READY       <= 1'b0;
                    end
                end
                ST_PRE: begin
                    if (cnt_zero_c) begin
                        state      <= ST_LOAD;
                        DELAY_LOAD <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (cnt_zero_c) begin
                        state           <= ST_GAP;
                        HS_IO_CLK_PAUSE <= 1'b0;
                        DONE            <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_zero_c) begin
                        state     <= ST_IDLE;
                        BUSY      <= 1'b0;
                        REQ_READY <= 1'b1;
                    end
                end
                default: begin
                    state           <= ST_IDLE;
                    HS_IO_CLK_PAUSE <= 1'b0;
                    BUSY            <= 1'b0;
                    REQ_READY       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lanectrl_pause_gen.sv
// Bench for lanectrl_pause_gen: timeline model plus directed literal checks and random traffic.
module tb_lanectrl_pause_gen;

    localparam int unsigned P0 = 2, H0 = 4, G0 = 8;
    localparam int unsigned P1 = 1, H1 = 1, G1 = 2;

    logic       clk;
    logic       rst_n;
    logic       v0, v1;
    logic [7:0] c0, c1;

    logic       rdy0, pz0, ld0, dn0, bz0;
    logic [7:0] cd0;
    logic       rdy1, pz1, ld1, dn1, bz1;
    logic [7:0] cd1;

    int checks = 0;
    int errors = 0;

    lanectrl_pause_gen #(
        .PRE_CYCLES(P0), .HOLD_CYCLES(H0), .GAP_CYCLES(G0), .CODE_W(8), .CNT_W(4)
    ) dut0 (
        .CLK(clk), .RESET_N(rst_n), .REQ_VALID(v0), .REQ_CODE(c0),
        .REQ_READY(rdy0), .HS_IO_CLK_PAUSE(pz0), .DELAY_LOAD(ld0),
        .DELAY_CODE(cd0), .DONE(dn0), .BUSY(bz0)
    );

    lanectrl_pause_gen #(
        .PRE_CYCLES(P1), .HOLD_CYCLES(H1), .GAP_CYCLES(G1), .CODE_W(8), .CNT_W(4)
    ) dut1 (
        .CLK(clk), .RESET_N(rst_n), .REQ_VALID(v1), .REQ_CODE(c1),
        .REQ_READY(rdy1), .HS_IO_CLK_PAUSE(pz1), .DELAY_LOAD(ld1),
        .DELAY_CODE(cd1), .DONE(dn1), .BUSY(bz1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: t = cycles elapsed since acceptance (0 = idle); a window spans PRE+1+HOLD+GAP cycles.
    int         t0 = 0, t1 = 0;
    logic [7:0] mc0 = 8'h00, mc1 = 8'h00;

    always @(posedge clk) begin
        if (!rst_n) begin
            t0 <= 0; mc0 <= 8'h00;
            t1 <= 0; mc1 <= 8'h00;
        end else begin
            if (t0 == 0) begin
                if (v0) begin t0 <= 1; mc0 <= c0; end
            end else begin
                t0 <= (t0 == int'(P0 + 1 + H0 + G0)) ? 0 : t0 + 1;
            end
            if (t1 == 0) begin
                if (v1) begin t1 <= 1; mc1 <= c1; end
            end else begin
                t1 <= (t1 == int'(P1 + 1 + H1 + G1)) ? 0 : t1 + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_cmp(input string tag, input int t, input int p, input int h,
                             input logic [7:0] mc, input logic rdy, input logic pz,
                             input logic ld, input logic dn, input logic bz,
                             input logic [7:0] cd);
        chk({tag, "_ready"}, 32'(rdy), 32'(t == 0));
        chk({tag, "_pause"}, 32'(pz),  32'(t >= 1 && t <= p + 1 + h));
        chk({tag, "_load"},  32'(ld),  32'(t == p + 1));
        chk({tag, "_done"},  32'(dn),  32'(t == p + h + 2));
        chk({tag, "_busy"},  32'(bz),  32'(t != 0));
        chk({tag, "_code"},  32'(cd),  32'(mc));
    endtask

    // Advance one cycle and compare both DUTs against the model away from the active edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        model_cmp("m0", t0, int'(P0), int'(H0), mc0, rdy0, pz0, ld0, dn0, bz0, cd0);
        model_cmp("m1", t1, int'(P1), int'(H1), mc1, rdy1, pz1, ld1, dn1, bz1, cd1);
    endtask

    initial begin
        rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; c0 = 8'h00; c1 = 8'h00;

        // Reset then idle
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_ready", 32'(rdy0), 32'd1);
        chk("rst_pause", 32'(pz0),  32'd0);
        chk("rst_load",  32'(ld0),  32'd0);
        chk("rst_done",  32'(dn0),  32'd0);
        chk("rst_busy",  32'(bz0),  32'd0);
        chk("rst_code",  32'(cd0),  32'd0);

        // Single request 5A
        v0 = 1'b1; c0 = 8'h5A;
        step();
        v0 = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            if (n > 1) step();
            if (n == 1) chk("s_code_k1", 32'(cd0), 32'h5A);
            if (n == 1 || n == 7) chk("s_pause_hi", 32'(pz0), 32'd1);
            if (n == 8) chk("s_pause_lo", 32'(pz0), 32'd0);
            if (n == 2 || n == 4) chk("s_load_lo", 32'(ld0), 32'd0);
            if (n == 3) chk("s_load_k3", 32'(ld0), 32'd1);
            if (n == 8) chk("s_done_k8", 32'(dn0), 32'd1);
            if (n == 9) chk("s_done_k9", 32'(dn0), 32'd0);
            if (n == 15) chk("s_ready_k15", 32'(rdy0), 32'd0);
            if (n == 16) chk("s_ready_k16", 32'(rdy0), 32'd1);
        end

        // Continuous valid: 10 then 20
        v0 = 1'b1; c0 = 8'h10;
        step();
        c0 = 8'h20;
        for (int n = 1; n <= 20; n++) begin
            if (n > 1) step();
            if (n == 3) chk("b_load_k3", 32'(ld0), 32'd1);
            if (n == 16) chk("b_pause_k16", 32'(pz0), 32'd0);
            if (n == 17) chk("b_pause_k17", 32'(pz0), 32'd1);
            if (n == 17) chk("b_code_k17", 32'(cd0), 32'h20);
            if (n == 19) chk("b_load_k19", 32'(ld0), 32'd1);
        end
        v0 = 1'b0;
        repeat (14) step();
        chk("b_idle", 32'(rdy0), 32'd1);

        // Request during GAP is ignored
        v0 = 1'b1; c0 = 8'h33;
        step();
        v0 = 1'b0;
        repeat (9) step();
        v0 = 1'b1; c0 = 8'hFF;
        step();
        v0 = 1'b0;
        chk("g_code_k11", 32'(cd0), 32'h33);
        repeat (5) step();
        chk("g_ready_k16", 32'(rdy0), 32'd1);
        step();
        chk("g_nowin_pause", 32'(pz0), 32'd0);
        chk("g_nowin_code",  32'(cd0), 32'h33);

        // Reset mid-HOLD
        v0 = 1'b1; c0 = 8'h77;
        step();
        v0 = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("r_pause", 32'(pz0),  32'd0);
        chk("r_busy",  32'(bz0),  32'd0);
        chk("r_ready", 32'(rdy0), 32'd1);
        chk("r_done",  32'(dn0),  32'd0);
        for (int n = 0; n < 4; n++) begin
            step();
            chk("r_nodone", 32'(dn0), 32'd0);
        end

        // Short parameter set on dut1
        v1 = 1'b1; c1 = 8'h01;
        step();
        v1 = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            if (n > 1) step();
            chk("p_pause", 32'(pz1), 32'(n <= 3));
            chk("p_load",  32'(ld1), 32'(n == 2));
            chk("p_done",  32'(dn1), 32'(n == 4));
            chk("p_ready", 32'(rdy1), 32'(n == 6));
        end
        chk("p_code", 32'(cd1), 32'h01);

        // Random traffic with occasional reset
        for (int n = 0; n < 4000; n++) begin
            v0    = ($urandom_range(0, 3) == 0);
            c0    = 8'($urandom);
            v1    = ($urandom_range(0, 2) == 0);
            c1    = 8'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1'b1; v0 = 1'b0; v1 = 1'b0;
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
